// File: rtl/jogo_memoria_controle_if.sv
// Control/status bundle between the memory-game control unit and its datapath.
// master = control unit (drives strobes), slave = datapath side.
interface jogo_memoria_controle_if;
    logic       jogar;
    logic       jogada_feita;
    logic       jogada_correta;
    logic       enderecoIgualRodada;
    logic       fimL;
    logic       timeout;
    logic       zeraCR;
    logic       contaCR;
    logic       zeraE;
    logic       contaE;
    logic       limpaRC;
    logic       registraRC;
    logic       zeraLeds;
    logic       registraLeds;
    logic       contaT;
    logic       zeraT;
    logic       led_selector;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] db_estado;

    modport master (
        input  jogar, jogada_feita, jogada_correta,
        input  enderecoIgualRodada, fimL, timeout,
        output zeraCR, contaCR, zeraE, contaE,
        output limpaRC, registraRC, zeraLeds, registraLeds,
        output contaT, zeraT, led_selector,
        output pronto, ganhou, perdeu, db_estado
    );

    modport slave (
        output jogar, jogada_feita, jogada_correta,
        output enderecoIgualRodada, fimL, timeout,
        input  zeraCR, contaCR, zeraE, contaE,
        input  limpaRC, registraRC, zeraLeds, registraLeds,
        input  contaT, zeraT, led_selector,
        input  pronto, ganhou, perdeu, db_estado
    );
endinterface

// File: rtl/jogo_memoria_controle.sv
// Moore control unit for the memory game: playback, move checking, outcome.
// Define JOGO_TIMEOUT_EN to make a move-timer expiry end the game (state F).
module jogo_memoria_controle #(
    parameter int T_MOSTRA = 4,
    parameter int T_APAGA  = 2,
    parameter int CW       = 26
) (
    input logic              clock,
    input logic              reset,
    jogo_memoria_controle_if.master bus
);

    typedef enum logic [3:0] {
        INICIAL         = 4'h0,
        PREPARACAO      = 4'h1,
        INICIO_RODADA   = 4'h2,
        MOSTRA          = 4'h3,
        APAGA           = 4'h4,
        PROXIMO_LED     = 4'h5,
        PREPARA_JOGADAS = 4'h6,
        ESPERA_JOGADA   = 4'h7,
        REGISTRA        = 4'h8,
        COMPARA         = 4'h9,
        PROXIMA_JOGADA  = 4'hA,
        PROXIMA_RODADA  = 4'hB,
        FIM_ACERTOU     = 4'hD,
        FIM_ERROU       = 4'hE,
        FIM_TIMEOUT     = 4'hF
    } estado_t;

    localparam logic [CW-1:0] FIM_MOSTRA = CW'(T_MOSTRA - 1);
    localparam logic [CW-1:0] FIM_APAGA  = CW'(T_APAGA - 1);

    estado_t         estado_q, estado_d;
    logic [CW-1:0]   timer_q, timer_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    // Timer runs only during playback and restarts at every phase change.
    always_comb begin
        estado_d = estado_q;
        timer_d  = '0;
        unique case (estado_q)
            INICIAL:         if (bus.jogar) estado_d = PREPARACAO;
            PREPARACAO:      estado_d = INICIO_RODADA;
            INICIO_RODADA:   estado_d = MOSTRA;
            MOSTRA: begin
                if (timer_q == FIM_MOSTRA) estado_d = APAGA;
                else timer_d = timer_q + 1'b1;
            end
            APAGA: begin
                if (timer_q == FIM_APAGA)
                    estado_d = bus.enderecoIgualRodada ? PREPARA_JOGADAS
                                                       : PROXIMO_LED;
                else
                    timer_d = timer_q + 1'b1;
            end
            PROXIMO_LED:     estado_d = MOSTRA;
            PREPARA_JOGADAS: estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (bus.jogada_feita) estado_d = REGISTRA;
`ifdef JOGO_TIMEOUT_EN
                else if (bus.timeout) estado_d = FIM_TIMEOUT;
`endif
            end
            REGISTRA:        estado_d = COMPARA;
            COMPARA: begin
                if (!bus.jogada_correta)           estado_d = FIM_ERROU;
                else if (!bus.enderecoIgualRodada) estado_d = PROXIMA_JOGADA;
                else if (bus.fimL)                 estado_d = FIM_ACERTOU;
                else                               estado_d = PROXIMA_RODADA;
            end
            PROXIMA_JOGADA:  estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA:  estado_d = INICIO_RODADA;
            FIM_ACERTOU,
            FIM_ERROU:       if (bus.jogar) estado_d = PREPARACAO;
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT:     if (bus.jogar) estado_d = PREPARACAO;
`endif
            default:         estado_d = INICIAL;
        endcase
    end

    always_comb begin
        bus.zeraCR       = 1'b0;
        bus.contaCR      = 1'b0;
        bus.zeraE        = 1'b0;
        bus.contaE       = 1'b0;
        bus.limpaRC      = 1'b0;
        bus.registraRC   = 1'b0;
        bus.zeraLeds     = 1'b0;
        bus.registraLeds = 1'b0;
        bus.contaT       = 1'b0;
        bus.zeraT        = 1'b0;
        bus.led_selector = 1'b0;
        bus.pronto       = 1'b0;
        bus.ganhou       = 1'b0;
        bus.perdeu       = 1'b0;
        unique case (estado_q)
            PREPARACAO: begin
                bus.zeraCR   = 1'b1;
                bus.zeraE    = 1'b1;
                bus.zeraLeds = 1'b1;
                bus.limpaRC  = 1'b1;
                bus.zeraT    = 1'b1;
            end
            INICIO_RODADA: begin
                bus.zeraE    = 1'b1;
                bus.zeraLeds = 1'b1;
            end
            MOSTRA: begin
                bus.led_selector = 1'b1;
                bus.registraLeds = 1'b1;
            end
            APAGA:       bus.zeraLeds = 1'b1;
            PROXIMO_LED: bus.contaE   = 1'b1;
            PREPARA_JOGADAS: begin
                bus.zeraE    = 1'b1;
                bus.zeraT    = 1'b1;
                bus.zeraLeds = 1'b1;
            end
            ESPERA_JOGADA: bus.contaT = 1'b1;
            REGISTRA: begin
                bus.registraRC   = 1'b1;
                bus.registraLeds = 1'b1;
            end
            PROXIMA_JOGADA: begin
                bus.contaE = 1'b1;
                bus.zeraT  = 1'b1;
            end
            PROXIMA_RODADA: bus.contaCR = 1'b1;
            FIM_ACERTOU: begin
                bus.pronto = 1'b1;
                bus.ganhou = 1'b1;
            end
            FIM_ERROU: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
            end
`ifdef JOGO_TIMEOUT_EN
            FIM_TIMEOUT: begin
                bus.pronto = 1'b1;
                bus.perdeu = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_jogo_memoria_controle.sv
// Scoreboard bench for jogo_memoria_controle: expected state/outputs queued
// per clock, compared one cycle later against the DUT.
module tb_jogo_memoria_controle;

    logic clock = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    int   ncyc  = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [13:0] out;
    } exp_t;

    exp_t sb[$];

    jogo_memoria_controle_if bus ();

    jogo_memoria_controle dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Bit order of the observed/expected strobe vector.
    localparam int ZCR = 13, CCR = 12, ZE = 11, CE = 10, LRC = 9;
    localparam int RRC = 8, ZL = 7, RL = 6, CT = 5, ZT = 4;
    localparam int LS = 3, PR = 2, GA = 1, PE = 0;

    wire [13:0] obs = {
        bus.zeraCR, bus.contaCR, bus.zeraE, bus.contaE, bus.limpaRC,
        bus.registraRC, bus.zeraLeds, bus.registraLeds, bus.contaT,
        bus.zeraT, bus.led_selector, bus.pronto, bus.ganhou, bus.perdeu
    };

    function automatic logic [13:0] saidas(input logic [3:0] st);
        logic [13:0] o;
        o = '0;
        case (st)
            4'h1: begin
                o[ZCR] = 1; o[ZE] = 1; o[ZL] = 1; o[LRC] = 1; o[ZT] = 1;
            end
            4'h2: begin o[ZE] = 1; o[ZL] = 1; end
            4'h3: begin o[LS] = 1; o[RL] = 1; end
            4'h4: o[ZL] = 1;
            4'h5: o[CE] = 1;
            4'h6: begin o[ZE] = 1; o[ZT] = 1; o[ZL] = 1; end
            4'h7: o[CT] = 1;
            4'h8: begin o[RRC] = 1; o[RL] = 1; end
            4'hA: begin o[CE] = 1; o[ZT] = 1; end
            4'hB: o[CCR] = 1;
            4'hD: begin o[PR] = 1; o[GA] = 1; end
            4'hE: begin o[PR] = 1; o[PE] = 1; end
            4'hF: begin o[PR] = 1; o[PE] = 1; end
            default: ;
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc %0d got %h expected %h", tag, ncyc, got, exp);
        end
    endtask

    // One clock: queue what the DUT must show after this edge, then compare.
    task automatic cyc(input logic [3:0] st);
        exp_t e;
        sb.push_back('{st: st, out: saidas(st)});
        @(posedge clock);
        #1;
        ncyc++;
        e = sb.pop_front();
        chk("estado", {12'd0, bus.db_estado}, {12'd0, e.st});
        chk("saidas", {2'd0, obs}, {2'd0, e.out});
    endtask

    // Playback of n LEDs, address matching the round only on the last one.
    task automatic mostra(input int n);
        for (int i = 0; i < n; i++) begin
            bus.enderecoIgualRodada = 1'b0;
            repeat (4) cyc(4'h3);
            repeat (2) cyc(4'h4);
            if (i < n - 1) begin
                cyc(4'h5);
            end else begin
                bus.enderecoIgualRodada = 1'b1;
                cyc(4'h6);
            end
        end
    endtask

    task automatic jogada(input logic ok, input logic eq, input logic fim);
        bus.jogada_feita        = 1'b1;
        bus.jogada_correta      = ok;
        bus.enderecoIgualRodada = eq;
        bus.fimL                = fim;
        cyc(4'h8);
        bus.jogada_feita = 1'b0;
        cyc(4'h9);
    endtask

    initial begin
        bus.jogar               = 1'b0;
        bus.jogada_feita        = 1'b0;
        bus.jogada_correta      = 1'b0;
        bus.enderecoIgualRodada = 1'b0;
        bus.fimL                = 1'b0;
        bus.timeout             = 1'b0;
        reset                   = 1'b1;
        #2;
        cyc(4'h0);
        cyc(4'h0);
        reset = 1'b0;

        // round 0: one LED, correct move, next round
        bus.jogar = 1'b1;
        cyc(4'h1);
        bus.jogar = 1'b0;
        cyc(4'h2);
        mostra(1);
        cyc(4'h7);
        cyc(4'h7);
        jogada(1'b1, 1'b1, 1'b0);
        cyc(4'hB);
        cyc(4'h2);

        // round 1: two LEDs, first move advances, second is wrong
        mostra(2);
        cyc(4'h7);
        jogada(1'b1, 1'b0, 1'b0);
        cyc(4'hA);
        cyc(4'h7);
        bus.timeout = 1'b1;
        bus.jogada_feita   = 1'b1;
        bus.jogada_correta = 1'b0;
        cyc(4'h8);
        bus.timeout      = 1'b0;
        bus.jogada_feita = 1'b0;
        cyc(4'h9);
        cyc(4'hE);
        cyc(4'hE);
        bus.jogar = 1'b1;
        cyc(4'h1);
        bus.jogar = 1'b0;
        cyc(4'h2);
        mostra(1);
        cyc(4'h7);

        // timeout alone in espera_jogada
        bus.timeout = 1'b1;
`ifdef JOGO_TIMEOUT_EN
        cyc(4'hF);
        bus.timeout = 1'b0;
        bus.jogar   = 1'b1;
        cyc(4'h1);
        bus.jogar = 1'b0;
        cyc(4'h2);
        mostra(1);
        cyc(4'h7);
`else
        cyc(4'h7);
        bus.jogar = 1'b1;
        cyc(4'h7);
        bus.jogar   = 1'b0;
        bus.timeout = 1'b0;
`endif

        // last round won, held jogar restarts
        jogada(1'b1, 1'b1, 1'b1);
        cyc(4'hD);
        cyc(4'hD);
        bus.jogar = 1'b1;
        cyc(4'h1);
        cyc(4'h2);
        bus.jogar = 1'b0;
        cyc(4'h3);
        cyc(4'h3);

        // reset during playback
        reset = 1'b1;
        cyc(4'h0);
        reset = 1'b0;
        cyc(4'h0);
        bus.jogar = 1'b1;
        cyc(4'h1);
        bus.jogar = 1'b0;
        cyc(4'h2);
        mostra(1);

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard left %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
